// File: rtl/row_pkg.sv
// Shared constants and encodings for the row packer and its row buffers.
package row_pkg;

  // Default geometry. The top module has its own parameters and derives its
  // widths from them.
  localparam int COL_DEF   = 256;
  localparam int ROW_DEF   = 256;
  localparam int WIDTH_DEF = 8;
  localparam int PIX_W     = 3 * WIDTH_DEF;
  localparam int ROW_W     = COL_DEF * PIX_W;

  // Packer FSM encoding.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Occupancy of one ping-pong buffer.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Bits per {R,G,B} pixel for a given channel width.
  function automatic int pix_width(input int width);
    return 3 * width;
  endfunction

endpackage

// File: rtl/row_buffer.sv
// One row of pixel storage with a full/empty flag and a parallel read-out.
// Column 0 is placed in the most significant pixel slot of rd_row_o.
module row_buffer
  import row_pkg::*;
#(
  parameter int COL = COL_DEF,
  parameter int PW  = PIX_W,
  parameter int CW  = $clog2(COL_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [CW-1:0]     wr_col_i,
  input  logic [PW-1:0]     wr_pix_i,
  input  logic              set_full_i,
  input  logic              clr_i,
  output logic              full_o,
  output logic              full_nxt_o,
  output logic [COL*PW-1:0] rd_row_o
);

  logic [PW-1:0] mem_q [COL];
  buf_state_e    flag_q, flag_d;

  // Pixel store: written one column at a time.
  // NOTE: the pixel array has no reset; the full flag alone decides whether
  // its contents are meaningful, which keeps a wide reset tree off the data.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_col_i] <= wr_pix_i;
    end
  end

  // Next occupancy: a flush or hand-off empties, completing the row fills.
  always_comb begin
    flag_d = flag_q;
    if (clr_i) begin
      flag_d = BUF_EMPTY;
    end else if (set_full_i) begin
      flag_d = BUF_FULL;
    end
  end

  // Occupancy flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flag_q <= BUF_EMPTY;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign full_o     = (flag_q == BUF_FULL);
  assign full_nxt_o = (flag_d == BUF_FULL);

  // Flatten the array: pixel j sits at the j-th slot counted from the MSB end.
  always_comb begin
    rd_row_o = '0;
    for (int j = 0; j < COL; j++) begin
      rd_row_o[COL*PW-1-PW*j -: PW] = mem_q[j];
    end
  end

endmodule

// File: rtl/row_packer.sv
// Packs a one-pixel-per-cycle RGB stream into full rows for a row-parallel
// consumer. Two row buffers alternate so the input keeps flowing while a
// finished row waits for row_ready.
module row_packer
  import row_pkg::*;
#(
  parameter int COL   = 256,
  parameter int ROW   = 256,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [3*WIDTH-1:0]       pix_in,
  input  logic                     pix_sof,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [COL*3*WIDTH-1:0]   row_out,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [$clog2(ROW)-1:0]   row_idx,
  output logic                     frame_done,
  output logic                     err_short
);

  localparam int PW  = pix_width(WIDTH);
  localparam int RW  = COL * PW;
  localparam int CW  = $clog2(COL);
  localparam int RIW = $clog2(ROW);
  localparam logic [CW-1:0]  COL_LAST = CW'(COL - 1);
  localparam logic [RIW-1:0] ROW_LAST = RIW'(ROW - 1);

  logic [0:0]     state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RIW-1:0] pack_q, pack_d;
  logic [RIW-1:0] row_idx_q, row_idx_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic           pix_ready_q, pix_ready_d;
  logic           frame_done_q, frame_done_d;
  logic           err_short_q, err_short_d;

  logic           accept;
  logic           handoff;
  logic [1:0]     buf_wr, buf_set, buf_clr;
  logic [1:0]     buf_full, buf_full_nxt;
  logic [CW-1:0]  wr_col;
  logic [RW-1:0]  buf_row [2];

  // Ping-pong pair; both see the same write data and column.
  for (genvar b = 0; b < 2; b++) begin : g_buf
    row_buffer #(
      .COL (COL),
      .PW  (PW),
      .CW  (CW)
    ) u_buf (
      .clk_i      (CLK),
      .rst_i      (RST),
      .wr_en_i    (buf_wr[b]),
      .wr_col_i   (wr_col),
      .wr_pix_i   (pix_in),
      .set_full_i (buf_set[b]),
      .clr_i      (buf_clr[b]),
      .full_o     (buf_full[b]),
      .full_nxt_o (buf_full_nxt[b]),
      .rd_row_o   (buf_row[b])
    );
  end

  assign accept    = pix_valid && pix_ready_q;
  assign row_valid = buf_full[rd_ptr_q];
  assign handoff   = row_valid && row_ready;

  // Next-state for pointers, counters, FSM and buffer controls. The hand-off
  // is evaluated first so that a mid-frame restart overrides its effects.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    pack_d       = pack_q;
    row_idx_d    = row_idx_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_done_d = 1'b0;
    err_short_d  = 1'b0;
    buf_wr       = '0;
    buf_set      = '0;
    buf_clr      = '0;
    wr_col       = col_q;

    if (handoff) begin
      buf_clr[rd_ptr_q] = 1'b1;
      rd_ptr_d          = ~rd_ptr_q;
      if (row_idx_q == ROW_LAST) begin
        row_idx_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        row_idx_d = row_idx_q + 1'b1;
      end
    end

    if (accept) begin
      if (pix_sof) begin
        // A start of frame anywhere but the very beginning aborts the frame:
        // drop everything pending and restart row numbering.
        if (state_q == ST_ACTIVE && (col_q != '0 || pack_q != '0)) begin
          err_short_d = 1'b1;
          buf_clr     = 2'b11;
          rd_ptr_d    = wr_ptr_q;
          row_idx_d   = '0;
          pack_d      = '0;
        end
        buf_wr[wr_ptr_q] = 1'b1;
        wr_col           = '0;
        col_d            = CW'(1);
        state_d          = ST_ACTIVE;
      end else if (state_q == ST_ACTIVE) begin
        buf_wr[wr_ptr_q] = 1'b1;
        if (col_q == COL_LAST) begin
          col_d             = '0;
          buf_set[wr_ptr_q] = 1'b1;
          wr_ptr_d          = ~wr_ptr_q;
          if (pack_q == ROW_LAST) begin
            pack_d  = '0;
            state_d = ST_IDLE;
          end else begin
            pack_d = pack_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      // IDLE without sof: the pixel is accepted and dropped.
    end
  end

  // Accept next cycle only if the buffer we will be writing is not full.
  assign pix_ready_d = ~buf_full_nxt[wr_ptr_d];

  // Control state registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      pack_q       <= '0;
      row_idx_q    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      pix_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      pack_q       <= pack_d;
      row_idx_q    <= row_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pix_ready_q  <= pix_ready_d;
      frame_done_q <= frame_done_d;
      err_short_q  <= err_short_d;
    end
  end

  // Stale buffer contents never reach the output: zero unless a row is ready.
  assign row_out    = row_valid ? buf_row[rd_ptr_q] : '0;
  assign pix_ready  = pix_ready_q;
  assign row_idx    = row_idx_q;
  assign frame_done = frame_done_q;
  assign err_short  = err_short_q;

endmodule

// File: tb/tb_row_packer.sv
// Bench for row_packer: a 4x2 instance driven from a cycle-by-cycle vector
// table plus hand-written backpressure and reset sequences, and a 256x256
// instance streaming one full frame.
module tb_row_packer;

  localparam int PW  = 24;
  localparam int SC  = 4;
  localparam int SR  = 2;
  localparam int SRW = SC * PW;
  localparam int DC  = 256;
  localparam int DR  = 256;
  localparam int DRW = DC * PW;

  localparam logic [SRW-1:0] ROW_A = 96'h000001_000002_000003_000004;
  localparam logic [SRW-1:0] ROW_B = 96'h000005_000006_000007_000008;
  localparam logic [SRW-1:0] ROW_C = 96'h000A01_000A02_000A03_000A04;
  localparam logic [SRW-1:0] ROW_D = 96'hAA0000_BB0000_CC0000_DD0000;
  localparam logic [SRW-1:0] ROW_E = 96'h000009_00000A_00000B_00000C;
  localparam logic [SRW-1:0] ROW_F = 96'h0000D1_0000D2_0000D3_0000D4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Small instance
  logic           rst_s = 1'b1;
  logic [PW-1:0]  pix_in_s = '0;
  logic           pix_sof_s = 1'b0;
  logic           pix_valid_s = 1'b0;
  logic           pix_ready_s;
  logic [SRW-1:0] row_out_s;
  logic           row_valid_s;
  logic           row_ready_s = 1'b0;
  logic [0:0]     row_idx_s;
  logic           frame_done_s;
  logic           err_short_s;

  // Default-size instance
  logic           rst_d = 1'b1;
  logic [PW-1:0]  pix_in_d = '0;
  logic           pix_sof_d = 1'b0;
  logic           pix_valid_d = 1'b0;
  logic           pix_ready_d;
  logic [DRW-1:0] row_out_d;
  logic           row_valid_d;
  logic           row_ready_d = 1'b0;
  logic [7:0]     row_idx_d;
  logic           frame_done_d;
  logic           err_short_d;

  row_packer #(.COL(SC), .ROW(SR), .WIDTH(8)) dut_s (
    .CLK        (CLK),
    .RST        (rst_s),
    .pix_in     (pix_in_s),
    .pix_sof    (pix_sof_s),
    .pix_valid  (pix_valid_s),
    .pix_ready  (pix_ready_s),
    .row_out    (row_out_s),
    .row_valid  (row_valid_s),
    .row_ready  (row_ready_s),
    .row_idx    (row_idx_s),
    .frame_done (frame_done_s),
    .err_short  (err_short_s)
  );

  row_packer dut_d (
    .CLK        (CLK),
    .RST        (rst_d),
    .pix_in     (pix_in_d),
    .pix_sof    (pix_sof_d),
    .pix_valid  (pix_valid_d),
    .pix_ready  (pix_ready_d),
    .row_out    (row_out_d),
    .row_valid  (row_valid_d),
    .row_ready  (row_ready_d),
    .row_idx    (row_idx_d),
    .frame_done (frame_done_d),
    .err_short  (err_short_d)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One table row: inputs held across an edge, outputs expected after it.
  typedef struct {
    logic           rst;
    logic           sof;
    logic           valid;
    logic           rr;
    logic [PW-1:0]  pix;
    logic           e_pr;
    logic           e_rv;
    logic [SRW-1:0] e_ro;
    logic           e_idx;
    logic           e_fd;
    logic           e_es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic sof, input logic valid,
                              input logic rr, input logic [PW-1:0] pix,
                              input logic e_pr, input logic e_rv, input logic [SRW-1:0] e_ro,
                              input logic e_idx, input logic e_fd, input logic e_es);
    vec_t v;
    v.rst = rst; v.sof = sof; v.valid = valid; v.rr = rr; v.pix = pix;
    v.e_pr = e_pr; v.e_rv = e_rv; v.e_ro = e_ro; v.e_idx = e_idx;
    v.e_fd = e_fd; v.e_es = e_es;
    return v;
  endfunction

  // Present one pixel to the small instance until it is taken (bounded).
  task automatic send_s(input logic [PW-1:0] p, input logic sof);
    bit taken;
    bit acc;
    taken = 1'b0;
    pix_in_s    = p;
    pix_sof_s   = sof;
    pix_valid_s = 1'b1;
    for (int c = 0; c < 50 && !taken; c++) begin
      acc = pix_ready_s;
      @(posedge CLK); #1;
      taken = acc;
    end
    pix_valid_s = 1'b0;
    pix_sof_s   = 1'b0;
    if (!taken) check("send_s_timeout", 0, 1);
  endtask

  task automatic reset_s();
    rst_s = 1'b1;
    pix_valid_s = 1'b0;
    pix_sof_s   = 1'b0;
    row_ready_s = 1'b0;
    @(posedge CLK); #1;
    rst_s = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Default-instance row monitor: checks each row as it is handed off.
  bit mon_en   = 1'b0;
  int handoffs = 0;
  int fd_cnt   = 0;

  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (frame_done_d) fd_cnt++;
        if (row_valid_d && row_ready_d) begin
          int nbad;
          nbad = 0;
          for (int j = 0; j < DC; j++) begin
            if (row_out_d[DRW-1-PW*j -: PW] !== 24'(handoffs * DC + j)) nbad++;
          end
          check($sformatf("dflt_row%0d_bad_pixels", handoffs), nbad, 0);
          check($sformatf("dflt_row%0d_idx", handoffs), row_idx_d, handoffs);
          handoffs++;
        end
      end
    end
  end

  initial begin
    // ---------------- table-driven segments ----------------
    // Straight 4x2 frame with row_ready held high.
    vecs.push_back(mk(1,0,0,1,24'h0,        0,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,0,1,24'h0,        1,0,'0,   0,0,0));
    vecs.push_back(mk(0,1,1,1,24'h000001,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,1,24'h000002,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,1,24'h000003,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,1,24'h000004,   1,1,ROW_A,0,0,0));
    vecs.push_back(mk(0,0,1,1,24'h000005,   1,0,'0,   1,0,0));
    vecs.push_back(mk(0,0,1,1,24'h000006,   1,0,'0,   1,0,0));
    vecs.push_back(mk(0,0,1,1,24'h000007,   1,0,'0,   1,0,0));
    vecs.push_back(mk(0,0,1,1,24'h000008,   1,1,ROW_B,1,0,0));
    vecs.push_back(mk(0,0,0,1,24'h0,        1,0,'0,   0,1,0));
    vecs.push_back(mk(0,0,0,1,24'h0,        1,0,'0,   0,0,0));
    // Pixels before sof are dropped; row held stable while row_ready low.
    vecs.push_back(mk(1,0,0,0,24'h0,        0,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,0,0,24'h0,        1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,0,24'h111111,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,0,24'h222222,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,0,24'h333333,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,1,1,0,24'h000A01,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,0,24'h000A02,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,0,24'h000A03,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,0,24'h000A04,   1,1,ROW_C,0,0,0));
    vecs.push_back(mk(0,0,0,0,24'h0,        1,1,ROW_C,0,0,0));
    vecs.push_back(mk(0,0,0,1,24'h0,        1,0,'0,   1,0,0));
    // Mid-row sof aborts the partial row.
    vecs.push_back(mk(1,0,0,1,24'h0,        0,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,0,1,24'h0,        1,0,'0,   0,0,0));
    vecs.push_back(mk(0,1,1,1,24'h010101,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,1,24'h020202,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,1,24'h030303,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,1,1,1,24'hAA0000,   1,0,'0,   0,0,1));
    vecs.push_back(mk(0,0,1,1,24'hBB0000,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,1,24'hCC0000,   1,0,'0,   0,0,0));
    vecs.push_back(mk(0,0,1,1,24'hDD0000,   1,1,ROW_D,0,0,0));
    vecs.push_back(mk(0,0,0,1,24'h0,        1,0,'0,   1,0,0));

    @(posedge CLK); #1;
    foreach (vecs[i]) begin
      rst_s       = vecs[i].rst;
      pix_sof_s   = vecs[i].sof;
      pix_valid_s = vecs[i].valid;
      row_ready_s = vecs[i].rr;
      pix_in_s    = vecs[i].pix;
      @(posedge CLK); #1;
      check($sformatf("v%0d_pix_ready", i),  pix_ready_s,  vecs[i].e_pr);
      check($sformatf("v%0d_row_valid", i),  row_valid_s,  vecs[i].e_rv);
      check($sformatf("v%0d_row_out", i),    row_out_s,    vecs[i].e_ro);
      check($sformatf("v%0d_row_idx", i),    row_idx_s,    vecs[i].e_idx);
      check($sformatf("v%0d_frame_done", i), frame_done_s, vecs[i].e_fd);
      check($sformatf("v%0d_err_short", i),  err_short_s,  vecs[i].e_es);
    end

    // ---------------- backpressure ----------------
    reset_s();
    row_ready_s = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      send_s(24'(k), k == 1);
      check($sformatf("bp_ready_after_px%0d", k), pix_ready_s, (k < 8) ? 1 : 0);
    end
    check("bp_row_valid", row_valid_s, 1);
    pix_in_s = 24'h000009; pix_sof_s = 1'b1; pix_valid_s = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      check("bp_stall_ready", pix_ready_s, 0);
      check("bp_stall_row_out", row_out_s, ROW_A);
      check("bp_stall_row_idx", row_idx_s, 0);
    end
    row_ready_s = 1'b1;
    @(posedge CLK); #1;
    row_ready_s = 1'b0;
    check("bp_ready_restored", pix_ready_s, 1);
    check("bp_second_row", row_out_s, ROW_B);
    check("bp_second_idx", row_idx_s, 1);
    @(posedge CLK); #1;          // pixel 9 (sof) taken into the freed buffer
    pix_valid_s = 1'b0; pix_sof_s = 1'b0;
    check("bp_ready_after_px9", pix_ready_s, 1);
    for (int k = 10; k <= 12; k++) send_s(24'(k), 1'b0);
    check("bp_ready_both_full", pix_ready_s, 0);
    check("bp_row_out_held", row_out_s, ROW_B);
    row_ready_s = 1'b1;
    @(posedge CLK); #1;
    row_ready_s = 1'b0;
    check("bp_frame_done", frame_done_s, 1);
    check("bp_third_row", row_out_s, ROW_E);
    check("bp_third_idx", row_idx_s, 0);
    check("bp_ready_final", pix_ready_s, 1);

    // ---------------- asynchronous reset mid-row ----------------
    reset_s();
    row_ready_s = 1'b0;
    send_s(24'h0000B1, 1'b1);
    for (int k = 2; k <= 4; k++) send_s(24'h0000B0 + 24'(k), 1'b0);
    send_s(24'h0000C1, 1'b0);
    send_s(24'h0000C2, 1'b0);
    check("rst_pre_row_valid", row_valid_s, 1);
    #3;
    rst_s = 1'b1;
    #1;
    check("rst_async_pix_ready", pix_ready_s, 0);
    check("rst_async_row_valid", row_valid_s, 0);
    check("rst_async_row_out", row_out_s, 0);
    @(posedge CLK); #1;
    rst_s = 1'b0;
    @(posedge CLK); #1;
    check("rst_release_ready", pix_ready_s, 1);
    send_s(24'h0000D1, 1'b1);
    for (int k = 2; k <= 4; k++) send_s(24'h0000D0 + 24'(k), 1'b0);
    check("rst_new_row_valid", row_valid_s, 1);
    check("rst_new_row_out", row_out_s, ROW_F);
    check("rst_new_row_idx", row_idx_s, 0);

    // ---------------- full default frame ----------------
    begin
      int idx;
      int stalls;
      int cyc;
      bit acc;
      idx = 0; stalls = 0; cyc = 0;
      rst_d = 1'b1;
      @(posedge CLK); #1;
      rst_d = 1'b0;
      @(posedge CLK); #1;
      row_ready_d = 1'b1;
      mon_en = 1'b1;
      while (idx < DC * DR && cyc < 70000) begin
        pix_in_d    = 24'(idx);
        pix_sof_d   = (idx == 0);
        pix_valid_d = 1'b1;
        acc = pix_ready_d;
        if (!acc) stalls++;
        @(posedge CLK); #1;
        if (acc) idx++;
        cyc++;
      end
      pix_valid_d = 1'b0;
      pix_sof_d   = 1'b0;
      for (int c = 0; c < 20 && handoffs < DR; c++) begin
        @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      mon_en = 1'b0;
      check("dflt_pixels_sent", idx, DC * DR);
      check("dflt_stalls", stalls, 0);
      check("dflt_handoffs", handoffs, DR);
      check("dflt_frame_done_pulses", fd_cnt, 1);
      check("dflt_err_short", err_short_d, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
